// File: rtl/ov_capture_pkg.sv
// rtl/ov_capture_pkg.sv - shared constants and state encoding for the camera capture path
package ov_capture_pkg;

   localparam int PIXEL_W      = 12;
   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;
   localparam int X_W          = 10;
   localparam int Y_W          = 9;

   // Encoding is shared with frame_buffer, keep values fixed
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SYNC    = 2'd1,
      CAPTURE = 2'd2
   } cap_state_t;

endpackage

// File: rtl/ov_capture_if.sv
// rtl/ov_capture_if.sv - camera byte bus in, RGB444 pixel stream out
interface ov_capture_if;
   import ov_capture_pkg::*;

   logic               vsync;
   logic               href;
   logic [7:0]         cam_d;
   logic [PIXEL_W-1:0] pixel_data;
   logic               pixel_valid;
   logic               frame_done;
   logic [X_W-1:0]     pixel_x;
   logic [Y_W-1:0]     pixel_y;

   // master: the capture stage; slave: camera model / downstream consumer
   modport master (
      input  vsync, href, cam_d,
      output pixel_data, pixel_valid, frame_done, pixel_x, pixel_y
   );
   modport slave (
      output vsync, href, cam_d,
      input  pixel_data, pixel_valid, frame_done, pixel_x, pixel_y
   );

endinterface

// File: rtl/ov_capture_edge_detect.sv
// rtl/ov_capture_edge_detect.sv - previous-value register with rise/fall decode
module ov_capture_edge_detect (
   input  logic p_clk,
   input  logic rst,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic prev;

   // Remember last sampled level; edges are current sample vs this register
   always_ff @(posedge p_clk or negedge rst) begin
      if (!rst) prev <= 1'b0;
      else      prev <= d;
   end

   assign rise = d & ~prev;
   assign fall = ~d & prev;

endmodule

// File: rtl/ov_capture.sv
// rtl/ov_capture.sv - frame-aligned VSYNC/HREF capture, byte-pair to RGB444 packing
module ov_capture
   import ov_capture_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_DEF,
   parameter int V_ACTIVE = V_ACTIVE_DEF
) (
   input  logic         p_clk,
   input  logic         rst,
   input  logic         enable,
   ov_capture_if.master cam,
   output logic         line_err,
   output logic         frame_err,
   output logic         busy
);

   localparam logic [X_W-1:0] H_MAX = X_W'(H_ACTIVE);
   localparam logic [Y_W-1:0] V_MAX = Y_W'(V_ACTIVE);

   logic vs_rise, vs_fall, hr_fall, hr_rise_unused;

   ov_capture_edge_detect u_vs_edge (
      .p_clk(p_clk), .rst(rst), .d(cam.vsync), .rise(vs_rise), .fall(vs_fall)
   );
   ov_capture_edge_detect u_hr_edge (
      .p_clk(p_clk), .rst(rst), .d(cam.href), .rise(hr_rise_unused), .fall(hr_fall)
   );

   cap_state_t         state_q, state_n;
   logic [X_W-1:0]     x_cnt, x_n, px_q, px_n;
   logic [Y_W-1:0]     y_cnt, y_n, py_q, py_n;
   logic               phase, phase_n;
   logic [3:0]         r_q, r_n;
   logic [PIXEL_W-1:0] data_q, data_n;
   logic               valid_q, valid_n, done_q, done_n;
   logic               lerr_n, ferr_n, busy_n;

   // State and all registered outputs
   always_ff @(posedge p_clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         x_cnt     <= '0;
         y_cnt     <= '0;
         phase     <= 1'b0;
         r_q       <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         done_q    <= 1'b0;
         px_q      <= '0;
         py_q      <= '0;
         line_err  <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_n;
         x_cnt     <= x_n;
         y_cnt     <= y_n;
         phase     <= phase_n;
         r_q       <= r_n;
         data_q    <= data_n;
         valid_q   <= valid_n;
         done_q    <= done_n;
         px_q      <= px_n;
         py_q      <= py_n;
         line_err  <= lerr_n;
         frame_err <= ferr_n;
         busy      <= busy_n;
      end
   end

   // Next state plus packing, coordinate and error bookkeeping; bytes, then line end, then frame end
   always_comb begin
      state_n = state_q;
      x_n     = x_cnt;
      y_n     = y_cnt;
      phase_n = phase;
      r_n     = r_q;
      data_n  = data_q;
      valid_n = 1'b0;
      done_n  = 1'b0;
      px_n    = px_q;
      py_n    = py_q;
      lerr_n  = line_err;
      ferr_n  = frame_err;

      unique case (state_q)
         IDLE: begin
            if (enable) state_n = SYNC;
         end
         SYNC: begin
            if (!enable) begin
               state_n = IDLE;
            end else if (vs_fall) begin
               state_n = CAPTURE;
               x_n     = '0;
               y_n     = '0;
               phase_n = 1'b0;
               lerr_n  = 1'b0;
               ferr_n  = 1'b0;
            end
         end
         CAPTURE: begin
            if (cam.href) begin
               if (!phase) begin
                  r_n     = cam.cam_d[3:0];
                  phase_n = 1'b1;
               end else begin
                  phase_n = 1'b0;
                  if (y_cnt >= V_MAX) begin
                     ferr_n = 1'b1;
                  end else if (x_cnt >= H_MAX) begin
                     lerr_n = 1'b1;
                  end else begin
                     valid_n = 1'b1;
                     data_n  = {r_q, cam.cam_d};
                     px_n    = x_cnt;
                     py_n    = y_cnt;
                     x_n     = x_cnt + 1'b1;
                  end
               end
            end else if (hr_fall) begin
               // Excess lines are already flagged as frame errors, so only judge in-frame lines
               if (y_cnt < V_MAX) begin
                  if (phase || (x_cnt != H_MAX)) lerr_n = 1'b1;
                  y_n = y_cnt + 1'b1;
               end
               x_n     = '0;
               phase_n = 1'b0;
            end
            if (vs_rise) begin
               done_n = 1'b1;
               if (y_n != V_MAX) ferr_n = 1'b1;
               state_n = enable ? SYNC : IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      busy_n = (state_n == CAPTURE);
   end

   assign cam.pixel_data  = data_q;
   assign cam.pixel_valid = valid_q;
   assign cam.frame_done  = done_q;
   assign cam.pixel_x     = px_q;
   assign cam.pixel_y     = py_q;

endmodule

// File: tb/tb_ov_capture.sv
// tb/tb_ov_capture.sv - directed vector and sequence bench for ov_capture
module tb_ov_capture;
   import ov_capture_pkg::*;

   localparam int H = 4;
   localparam int V = 3;

   logic p_clk = 1'b0;
   logic rst = 1'b0;
   logic enable = 1'b0;
   logic line_err, frame_err, busy;

   ov_capture_if cam ();

   ov_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
      .p_clk(p_clk), .rst(rst), .enable(enable), .cam(cam),
      .line_err(line_err), .frame_err(frame_err), .busy(busy)
   );

   always #5 p_clk = ~p_clk;

   typedef struct packed {
      logic        en, vs, hr;
      logic [7:0]  d;
      logic        v;
      logic [11:0] data;
      logic [9:0]  x;
      logic [8:0]  y;
      logic        done, lerr, ferr, bsy;
   } vec_t;

   typedef struct packed {
      logic [9:0]  x;
      logic [8:0]  y;
      logic [11:0] d;
   } pix_t;

   vec_t tbl [17];
   pix_t expq [$];
   pix_t exp_p;
   int   vecs = 0;
   int   errs = 0;
   int   strobes = 0;
   int   dones = 0;
   bit   mon_on = 1'b0;

   task automatic tick();
      @(posedge p_clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vecs++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", name, act, req);
      end
   endtask

   // Scoreboard: every strobe must match the next expected pixel
   always @(negedge p_clk) begin
      if (mon_on && cam.frame_done) dones++;
      if (mon_on && cam.pixel_valid) begin
         strobes++;
         vecs++;
         if (expq.size() == 0) begin
            errs++;
            $display("FAIL strobe: unexpected pixel x=%0d y=%0d data=%03h", cam.pixel_x, cam.pixel_y, cam.pixel_data);
         end else begin
            exp_p = expq.pop_front();
            if ({cam.pixel_x, cam.pixel_y, cam.pixel_data} !== exp_p) begin
               errs++;
               $display("FAIL pixel: got x=%0d y=%0d data=%03h want x=%0d y=%0d data=%03h",
                        cam.pixel_x, cam.pixel_y, cam.pixel_data, exp_p.x, exp_p.y, exp_p.d);
            end
         end
      end
   end

   task automatic send_line(input int nbytes, input int y, input bit accept, input bit fixed);
      logic [7:0] b, b0;
      int p;
      b0 = 8'h00;
      for (int k = 0; k < nbytes; k++) begin
         p = k / 2;
         if (fixed) b = (k % 2 == 0) ? 8'h0A : 8'hBC;
         else       b = (k % 2 == 0) ? (8'hF0 | 8'(p)) : 8'(p * 37 + y * 11 + 5);
         if (k % 2 == 0) b0 = b;
         else if (accept && p < H) expq.push_back({10'(p), 9'(y), b0[3:0], b});
         cam.href  = 1'b1;
         cam.cam_d = b;
         tick();
      end
      cam.href  = 1'b0;
      cam.cam_d = 8'h00;
      tick();
      tick();
   endtask

   task automatic send_frame(input int nlines, input int first_bytes, input bit fixed);
      for (int y = 0; y < nlines; y++)
         send_line((y == 0) ? first_bytes : 2 * H, y, (y < V), fixed);
   endtask

   task automatic vs_level(input logic lvl);
      cam.vsync = lvl;
      tick();
      tick();
   endtask

   initial begin
      cam.vsync = 1'b0;
      cam.href  = 1'b0;
      cam.cam_d = 8'h00;

      //            en vs hr d      v  data     x  y  dn le fe bsy
      tbl[0]  = '{1'b0,1'b0,1'b0,8'h00, 1'b0,12'h000,10'd0,9'd0, 1'b0,1'b0,1'b0,1'b0};
      tbl[1]  = '{1'b1,1'b0,1'b0,8'h00, 1'b0,12'h000,10'd0,9'd0, 1'b0,1'b0,1'b0,1'b0};
      tbl[2]  = '{1'b1,1'b1,1'b0,8'h00, 1'b0,12'h000,10'd0,9'd0, 1'b0,1'b0,1'b0,1'b0};
      tbl[3]  = '{1'b1,1'b1,1'b0,8'h00, 1'b0,12'h000,10'd0,9'd0, 1'b0,1'b0,1'b0,1'b0};
      tbl[4]  = '{1'b1,1'b0,1'b0,8'h00, 1'b0,12'h000,10'd0,9'd0, 1'b0,1'b0,1'b0,1'b1};
      tbl[5]  = '{1'b1,1'b0,1'b1,8'h0A, 1'b0,12'h000,10'd0,9'd0, 1'b0,1'b0,1'b0,1'b1};
      tbl[6]  = '{1'b1,1'b0,1'b1,8'hBC, 1'b1,12'hABC,10'd0,9'd0, 1'b0,1'b0,1'b0,1'b1};
      tbl[7]  = '{1'b1,1'b0,1'b1,8'hF5, 1'b0,12'hABC,10'd0,9'd0, 1'b0,1'b0,1'b0,1'b1};
      tbl[8]  = '{1'b1,1'b0,1'b1,8'h67, 1'b1,12'h567,10'd1,9'd0, 1'b0,1'b0,1'b0,1'b1};
      tbl[9]  = '{1'b1,1'b0,1'b1,8'h0F, 1'b0,12'h567,10'd1,9'd0, 1'b0,1'b0,1'b0,1'b1};
      tbl[10] = '{1'b1,1'b0,1'b1,8'h00, 1'b1,12'hF00,10'd2,9'd0, 1'b0,1'b0,1'b0,1'b1};
      tbl[11] = '{1'b1,1'b0,1'b1,8'h01, 1'b0,12'hF00,10'd2,9'd0, 1'b0,1'b0,1'b0,1'b1};
      tbl[12] = '{1'b1,1'b0,1'b1,8'h23, 1'b1,12'h123,10'd3,9'd0, 1'b0,1'b0,1'b0,1'b1};
      tbl[13] = '{1'b1,1'b0,1'b0,8'h00, 1'b0,12'h123,10'd3,9'd0, 1'b0,1'b0,1'b0,1'b1};
      tbl[14] = '{1'b1,1'b1,1'b0,8'h00, 1'b0,12'h123,10'd3,9'd0, 1'b1,1'b0,1'b1,1'b0};
      tbl[15] = '{1'b1,1'b1,1'b0,8'h00, 1'b0,12'h123,10'd3,9'd0, 1'b0,1'b0,1'b1,1'b0};
      tbl[16] = '{1'b1,1'b0,1'b0,8'h00, 1'b0,12'h123,10'd3,9'd0, 1'b0,1'b0,1'b0,1'b1};

      tick();
      tick();
      check("reset_outputs", {cam.pixel_valid, cam.pixel_data, cam.frame_done, cam.pixel_x,
                              cam.pixel_y, line_err, frame_err, busy}, 64'd0);
      rst = 1'b1;
      tick();

      // Cycle-level vectors: sync, pixel packing, short frame
      for (int i = 0; i < 17; i++) begin
         enable    = tbl[i].en;
         cam.vsync = tbl[i].vs;
         cam.href  = tbl[i].hr;
         cam.cam_d = tbl[i].d;
         tick();
         check($sformatf("vec%0d", i),
               {cam.pixel_valid, cam.pixel_data, cam.pixel_x, cam.pixel_y,
                cam.frame_done, line_err, frame_err, busy},
               {tbl[i].v, tbl[i].data, tbl[i].x, tbl[i].y,
                tbl[i].done, tbl[i].lerr, tbl[i].ferr, tbl[i].bsy});
      end
      cam.href  = 1'b0;
      cam.cam_d = 8'h00;
      mon_on    = 1'b1;

      // Well-formed frame with constant bytes
      strobes = 0; dones = 0;
      send_frame(V, 2 * H, 1'b1);
      vs_level(1'b1);
      check("full_strobes", strobes, H * V);
      check("full_done", dones, 1);
      check("full_errs", {line_err, frame_err, busy}, 3'b000);
      vs_level(1'b0);

      // Odd byte count on first line
      strobes = 0; dones = 0;
      send_line(2 * H + 1, 0, 1'b1, 1'b0);
      check("odd_lerr_now", line_err, 1'b1);
      send_line(2 * H, 1, 1'b1, 1'b0);
      send_line(2 * H, 2, 1'b1, 1'b0);
      vs_level(1'b1);
      check("odd_strobes", strobes, H * V);
      check("odd_errs_at_done", {line_err, frame_err, dones[1:0]}, 4'b1001);
      vs_level(1'b0);
      check("odd_lerr_cleared", {line_err, busy}, 2'b01);

      // One line too many
      strobes = 0; dones = 0;
      send_frame(V + 1, 2 * H, 1'b0);
      vs_level(1'b1);
      check("extra_strobes", strobes, H * V);
      check("extra_ferr", {frame_err, dones[1:0]}, 3'b101);
      vs_level(1'b0);

      // Enable dropped mid-frame: frame still completes, then idle
      strobes = 0; dones = 0;
      send_line(2 * H, 0, 1'b1, 1'b0);
      enable = 1'b0;
      send_line(2 * H, 1, 1'b1, 1'b0);
      send_line(2 * H, 2, 1'b1, 1'b0);
      vs_level(1'b1);
      check("dis_strobes", strobes, H * V);
      check("dis_done", {dones[1:0], frame_err, busy}, 4'b0100);
      vs_level(1'b0);
      send_line(2 * H, 0, 1'b0, 1'b0);
      check("dis_idle", {strobes, 1'b0 + busy}, {H * V, 1'b0});

      // Enable mid-frame: nothing until next vsync fall
      strobes = 0; dones = 0;
      enable = 1'b1;
      send_line(2 * H, 1, 1'b0, 1'b0);
      check("sync_wait_strobes", strobes, 0);
      vs_level(1'b1);
      vs_level(1'b0);
      send_frame(V, 2 * H, 1'b0);
      vs_level(1'b1);
      check("sync_frame", {strobes[7:0], dones[3:0], line_err, frame_err}, {8'(H * V), 4'd1, 2'b00});
      vs_level(1'b0);

      // Asynchronous reset while a pixel strobe is high
      strobes = 0; dones = 0;
      cam.href = 1'b1;
      cam.cam_d = 8'h0A; tick();
      cam.cam_d = 8'hBC; tick();
      check("pre_reset_strobe", {cam.pixel_valid, cam.pixel_data}, {1'b1, 12'hABC});
      rst = 1'b0;
      #1;
      check("async_reset", {cam.pixel_valid, cam.pixel_data, cam.frame_done, cam.pixel_x,
                            cam.pixel_y, line_err, frame_err, busy}, 64'd0);
      tick();
      rst = 1'b1;
      cam.href = 1'b0;
      cam.cam_d = 8'h00;
      vs_level(1'b1);
      check("no_done_after_reset", dones, 0);
      vs_level(1'b0);
      send_frame(V, 2 * H, 1'b1);
      vs_level(1'b1);
      check("recover_frame", {strobes[7:0], dones[3:0]}, {8'(H * V), 4'd1});
      check("queue_drained", expq.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/ov_capture.md
# ov_capture

Camera-side capture stage sitting directly upstream of `frame_buffer`. Samples the camera's VSYNC/HREF/8-bit data bus on the pixel clock, aligns to frame start, packs byte pairs into 12-bit RGB444 pixels, and presents them as `pixel_data`/`pixel_valid` with a one-cycle `frame_done` pulse at end of frame. Also tracks pixel coordinates and flags malformed lines and frames so the buffer only ever sees well-framed 640x480 data.

## Interface
- `H_ACTIVE`, 640, pixels per line
- `V_ACTIVE`, 480, lines per frame
- `p_clk`  in  1  camera pixel clock; all logic on its rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `enable`  in  1  continuous-capture enable, level-sensitive
- `vsync`  in  1  camera VSYNC, high = vertical blanking
- `href`  in  1  camera HREF, high = active bytes on `cam_d`
- `cam_d`  in  8  camera data byte
- `pixel_data`  out  12  RGB444 {R,G,B}
- `pixel_valid`  out  1  one-cycle strobe, `pixel_data` valid
- `frame_done`  out  1  one-cycle pulse, end of captured frame
- `pixel_x`  out  10  column of current `pixel_data`
- `pixel_y`  out  9  row of current `pixel_data`
- `line_err`  out  1  sticky: bad line seen in current frame
- `frame_err`  out  1  sticky: bad line count in current frame
- `busy`  out  1  high while state is CAPTURE

## Operation
- States: IDLE, SYNC, CAPTURE.
- IDLE: outputs quiescent; `enable`=1 -> SYNC.
- SYNC: wait for `vsync` falling edge (registered previous value 1, current 0) -> CAPTURE; clear x/y counters, byte phase, `line_err`, `frame_err`. `enable`=0 -> IDLE.
- CAPTURE, `href`=1: phase 0 latches `cam_d[3:0]` as R; phase 1 forms pixel {R, `cam_d[7:4]`, `cam_d[3:0]`} (G, B), pulses `pixel_valid`, increments x.
- Pixels with x >= `H_ACTIVE` are dropped (no strobe), `line_err` set.
- `href` falling edge: if phase 1 pending (odd byte count) or x != `H_ACTIVE` -> `line_err`; drop partial byte; x=0, phase=0; if y < `V_ACTIVE` then y+1. Lines past row `V_ACTIVE`-1 dropped, `frame_err` set.
- `vsync` rising edge in CAPTURE: pulse `frame_done`; `frame_err` set if y != `V_ACTIVE`; next state SYNC if `enable`=1, else IDLE. `enable` falling mid-frame has no effect until this edge.
- `pixel_x`/`pixel_y` hold coordinates of the pixel in `pixel_data`; x width 10, y width 9; counters saturate, never wrap.
- `line_err`/`frame_err` hold through `frame_done` and clear only on entry to CAPTURE.

## Timing
- Reset (`rst`=0, async): state IDLE; all outputs 0; phase, counters, edge registers 0.
- Inputs sampled directly on `p_clk` rising edge; all outputs registered.
- Latency: `pixel_valid` high in the cycle after the second byte of a pair is sampled; exactly one cycle wide, no back-pressure (downstream must accept every strobe).
- `frame_done`: high the cycle after `vsync` 0->1 is sampled; one cycle wide; never coincides with `pixel_valid` unless `href` and `vsync` rise together, in which case the pixel strobe completes in the same cycle as `frame_done`.
- Simultaneous `href` fall and `vsync` rise: line end processed first (errors updated), then `frame_done`.
- Minimum: 2 `p_clk` per pixel; max pixel rate `p_clk`/2.

## Structure
- Shared package: RGB444 pixel width (12), `H_ACTIVE`/`V_ACTIVE` defaults, state encoding constants (IDLE=0, SYNC=1, CAPTURE=2) reused by `frame_buffer`.
- One natural sub-module: `edge_detect` (registered rise/fall pulses for `vsync`/`href`), instantiated twice.

## Test plan
- Reset mid-CAPTURE: `rst`=0 for 1 cycle -> all outputs 0 same cycle, state IDLE, no `frame_done` on later `vsync` rise until SYNC re-passed.
- Full 640x480 frame, bytes 0x0A,0xBC per pixel -> 307200 strobes, `pixel_data`=0xABC, last strobe x=639 y=479, one `frame_done`, no errors.
- Enable asserted mid-frame (`vsync`=0, `href` toggling) -> no strobes until next `vsync` fall; then full frame captured.
- Line with 1281 bytes -> 640 strobes, odd byte dropped, `line_err`=1 until next frame start.
- Frame with 481 lines -> line 481 produces no strobes, `frame_err`=1 at `frame_done`.
- `enable` deasserted at line 100 -> frame completes, `frame_done` pulses, state IDLE, `busy`=0.
